// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Holds the fetch PC, issues one request at a time to instruction memory,
// and presents the returned word with its PC to decode. A redirect from
// execute replaces the PC and squashes any stale in-flight fetch.
module ifu_fetch #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [31:0]           imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [31:0]           inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic        drop;      // outstanding response belongs to a squashed fetch
    logic [31:0] pc_q;
    logic [31:0] redir_tgt;

    // Redirect targets are word aligned; low bits are simply discarded.
    assign redir_tgt      = {redirect_pc[31:2], 2'b00};

    assign pc             = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = (state == REQ);

    // Fetch FSM: PC, squash flag and the decode-side output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;

                REQ: begin
                    // Address may move while unaccepted; memory only
                    // samples it on the handshake.
                    if (redirect_valid)
                        pc_q <= redir_tgt;
                    if (imem_req_ready) begin
                        state <= WAIT;
                        // Request already went out for the old PC: squash it.
                        drop  <= redirect_valid;
                    end
                end

                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!drop && !redirect_valid) begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc_q;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            if (redirect_valid)
                                pc_q <= redir_tgt;
                            drop  <= 1'b0;
                            state <= REQ;
                        end
                    end else if (redirect_valid) begin
                        pc_q <= redir_tgt;
                        drop <= 1'b1;
                    end
                end

                HOLD: begin
                    // Redirect wins over the sequential increment.
                    if (redirect_valid) begin
                        pc_q       <= redir_tgt;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        pc_q       <= pc_q + 32'd4;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
